mac_gated_tile: RTL and testbench

- Downstream consumer of mac_input_pipeline: receives `in_out`, `inst_out` and `q_zero` from the pipeline and performs an 8-lane dot product.
- Each lane is an 8-bit unsigned activation times an 8-bit signed weight, accumulated into a partial-sum register.
- Lanes whose activation is flagged zero (`q_zero`) or whose stored weight is zero are gated: the product register is not enabled and the lane contributes 0.
- Also keeps a saturating count of gated lane-operations, used for power/activity statistics.

---
 rtl/mac_gated_tile_if.sv | 29 ++
 rtl/mac_gated_tile.sv | 171 +++++++++++++++++
 tb/tb_mac_gated_tile.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_gated_tile_if.sv
// mac_gated_tile_if
//   Bus between the input pipeline (master) and the gated MAC tile (slave).
//   master drives : in_in, inst_in, q_zero, acc_clr
//   slave drives  : psum_out, valid_out, gated_cnt, w_zero
interface mac_gated_tile_if #(
    parameter int BW      = 8,
    parameter int LANES   = 8,
    parameter int PSUM_BW = 24,
    parameter int CNT_BW  = 16
);
    logic [BW*LANES-1:0] in_in;
    logic [1:0]          inst_in;
    logic [LANES-1:0]    q_zero;
    logic                acc_clr;
    logic [PSUM_BW-1:0]  psum_out;
    logic                valid_out;
    logic [CNT_BW-1:0]   gated_cnt;
    logic [LANES-1:0]    w_zero;

    modport master (
        output in_in, inst_in, q_zero, acc_clr,
        input  psum_out, valid_out, gated_cnt, w_zero
    );

    modport slave (
        input  in_in, inst_in, q_zero, acc_clr,
        output psum_out, valid_out, gated_cnt, w_zero
    );
endinterface

// File: rtl/mac_gated_tile.sv
// mac_gated_tile
//   8-lane unsigned-activation x signed-weight dot product with zero gating,
//   two-stage pipeline feeding a saturating signed accumulator.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mac_gated_tile_if.slave
//     in_in     activations (execute) / weights (load), byte i = lane i
//     inst_in   [1] execute, [0] load
//     q_zero    per-lane activation-zero flags
//     acc_clr   restart accumulation with this execute's dot product
//     psum_out  saturated signed partial sum
//     valid_out one-cycle pulse after an execute updates psum_out
//     gated_cnt saturating count of gated lane-operations
//     w_zero    zero mask of the stored weights
module mac_gated_tile #(
    parameter int BW      = 8,
    parameter int LANES   = 8,
    parameter int PSUM_BW = 24,
    parameter int CNT_BW  = 16
) (
    input  logic clk,
    input  logic reset,
    mac_gated_tile_if.slave bus
);
    localparam int PROD_W = 2 * BW + 1;
    localparam int DOT_W  = PROD_W + $clog2(LANES);
    localparam int SUM_W  = ((PSUM_BW > DOT_W) ? PSUM_BW : DOT_W) + 1;
    localparam int POP_W  = $clog2(LANES + 1);

    localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // A value fits PSUM_BW bits when all bits from the PSUM sign bit upward agree.
    function automatic logic signed [PSUM_BW-1:0] sat_psum(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-PSUM_BW:0] hi;
        hi = v[SUM_W-1:PSUM_BW-1];
        if ((&hi) || (~|hi)) begin
            return v[PSUM_BW-1:0];
        end else if (v[SUM_W-1]) begin
            return PSUM_MIN;
        end else begin
            return PSUM_MAX;
        end
    endfunction

    logic                       exe_s;
    logic                       load_s;
    logic [BW-1:0]              weight_q [LANES];
    logic [LANES-1:0]           w_zero_q;
    logic [LANES-1:0]           gate_s;
    logic signed [PROD_W-1:0]   prod_s   [LANES];
    logic signed [PROD_W-1:0]   prod_q   [LANES];
    logic [LANES-1:0]           gate_q;
    logic                       exe_q;
    logic                       clr_q;
    logic [POP_W-1:0]           pop_s;
    logic [CNT_BW:0]            cnt_sum_s;
    logic [CNT_BW-1:0]          gated_cnt_d;
    logic [CNT_BW-1:0]          gated_cnt_q;
    logic signed [DOT_W-1:0]    dot_s;
    logic signed [SUM_W-1:0]    sum_s;
    logic signed [PSUM_BW-1:0]  psum_d;
    logic signed [PSUM_BW-1:0]  psum_q;
    logic                       valid_q;

    assign exe_s  = bus.inst_in[1];
    assign load_s = bus.inst_in[0];

    // Stage-1 combinational: gate mask, lane products and gated-lane popcount.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < LANES; i++) begin
            gate_s[i] = bus.q_zero[i] | w_zero_q[i];
            prod_s[i] = $signed({{(PROD_W-BW){1'b0}}, bus.in_in[i*BW +: BW]})
                      * $signed({{(PROD_W-BW){weight_q[i][BW-1]}}, weight_q[i]});
            pop_s     = pop_s + POP_W'(gate_s[i]);
        end
    end

    // Gated-operation counter increment, pinned at all-ones once it overflows.
    always_comb begin
        cnt_sum_s = {1'b0, gated_cnt_q} + (CNT_BW+1)'(pop_s);
        if (!exe_s) begin
            gated_cnt_d = gated_cnt_q;
        end else if (cnt_sum_s[CNT_BW]) begin
            gated_cnt_d = {CNT_BW{1'b1}};
        end else begin
            gated_cnt_d = cnt_sum_s[CNT_BW-1:0];
        end
    end

    // Weight store; loads land at this edge so a same-cycle execute still sees the old set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                weight_q[i] <= '0;
            end
            w_zero_q <= '0;
        end else if (load_s) begin
            for (int i = 0; i < LANES; i++) begin
                weight_q[i] <= bus.in_in[i*BW +: BW];
                w_zero_q[i] <= (bus.in_in[i*BW +: BW] == {BW{1'b0}});
            end
        end
    end

    // Stage-1 registers; a gated lane's product register keeps its old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            gate_q      <= '0;
            exe_q       <= 1'b0;
            clr_q       <= 1'b0;
            gated_cnt_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (exe_s && !gate_s[i]) begin
                    prod_q[i] <= prod_s[i];
                end
            end
            if (exe_s) begin
                gate_q <= gate_s;
            end
            exe_q       <= exe_s;
            clr_q       <= bus.acc_clr;
            gated_cnt_q <= gated_cnt_d;
        end
    end

    // Stage-2 combinational: masked lane sum and next accumulator value.
    always_comb begin
        dot_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!gate_q[i]) begin
                dot_s = dot_s + DOT_W'(prod_q[i]);
            end else begin
                dot_s = dot_s;
            end
        end
        if (clr_q) begin
            sum_s = SUM_W'(dot_s);
        end else begin
            sum_s = SUM_W'(psum_q) + SUM_W'(dot_s);
        end
        if (exe_q) begin
            psum_d = sat_psum(sum_s);
        end else if (clr_q) begin
            psum_d = '0;
        end else begin
            psum_d = psum_q;
        end
    end

    // Stage-2 registers: accumulator and its update strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psum_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            psum_q  <= psum_d;
            valid_q <= exe_q;
        end
    end

    assign bus.psum_out  = psum_q;
    assign bus.valid_out = valid_q;
    assign bus.gated_cnt = gated_cnt_q;
    assign bus.w_zero    = w_zero_q;
endmodule

// File: tb/tb_mac_gated_tile.sv
// tb_mac_gated_tile
//   Drives two tiles (24-bit and 12-bit accumulators) with identical stimulus
//   and compares every cycle against an arithmetic reference model.
module tb_mac_gated_tile;
    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_s;
    logic [1:0]  inst_s;
    logic [7:0]  qz_s;
    logic        clr_s;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_w  [8];
    bit         m_wz [8];
    longint     m_psum24, m_psum12, m_cnt, p_dot;
    bit         p_exe, p_clr, m_valid;

    always #5 clk = ~clk;

    mac_gated_tile_if #(.PSUM_BW(24)) if24 ();
    mac_gated_tile_if #(.PSUM_BW(12)) if12 ();

    assign if24.in_in   = in_s;
    assign if24.inst_in = inst_s;
    assign if24.q_zero  = qz_s;
    assign if24.acc_clr = clr_s;
    assign if12.in_in   = in_s;
    assign if12.inst_in = inst_s;
    assign if12.q_zero  = qz_s;
    assign if12.acc_clr = clr_s;

    mac_gated_tile #(.PSUM_BW(24)) dut24 (.clk(clk), .reset(rst_n), .bus(if24));
    mac_gated_tile #(.PSUM_BW(12)) dut12 (.clk(clk), .reset(rst_n), .bus(if12));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int bw);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (bw - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint model_dot(input logic [63:0] din, input logic [7:0] qz);
        longint s = 0;
        for (int i = 0; i < 8; i++) begin
            if (!(qz[i] || m_wz[i])) begin
                s += longint'(din[8*i +: 8]) * longint'($signed(m_w[i]));
            end
        end
        return s;
    endfunction

    function automatic int model_gates(input logic [7:0] qz);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (qz[i] || m_wz[i]) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_w[i]  = 8'h00;
            m_wz[i] = 1'b0;
        end
        m_psum24 = 0;
        m_psum12 = 0;
        m_cnt    = 0;
        p_dot    = 0;
        p_exe    = 1'b0;
        p_clr    = 1'b0;
        m_valid  = 1'b0;
    endtask

    task automatic check_all();
        logic [7:0] wz;
        for (int i = 0; i < 8; i++) wz[i] = m_wz[i];
        chk("psum24",  $signed(if24.psum_out), m_psum24);
        chk("psum12",  $signed(if12.psum_out), m_psum12);
        chk("valid24", if24.valid_out, m_valid);
        chk("valid12", if12.valid_out, m_valid);
        chk("cnt24",   if24.gated_cnt, m_cnt);
        chk("cnt12",   if12.gated_cnt, m_cnt);
        chk("wzero24", if24.w_zero, wz);
        chk("wzero12", if12.w_zero, wz);
    endtask

    // One clock: drive inputs, advance the model by one edge, compare.
    task automatic cycle(input logic [63:0] din, input logic [1:0] inst,
                         input logic [7:0] qz, input logic clr);
        in_s = din; inst_s = inst; qz_s = qz; clr_s = clr;
        @(posedge clk);
        #1;
        m_valid = p_exe;
        if (p_exe) begin
            m_psum24 = sat(p_clr ? p_dot : m_psum24 + p_dot, 24);
            m_psum12 = sat(p_clr ? p_dot : m_psum12 + p_dot, 12);
        end else if (p_clr) begin
            m_psum24 = 0;
            m_psum12 = 0;
        end
        p_exe = inst[1];
        p_clr = clr;
        if (inst[1]) begin
            p_dot = model_dot(din, qz);
            m_cnt = m_cnt + model_gates(qz);
            if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        end
        if (inst[0]) begin
            for (int i = 0; i < 8; i++) begin
                m_w[i]  = din[8*i +: 8];
                m_wz[i] = (din[8*i +: 8] == 8'h00);
            end
        end
        check_all();
    endtask

    task automatic idle();
        cycle(64'h0, 2'b00, 8'h00, 1'b0);
    endtask

    localparam logic [63:0] ACT_A = 64'hAA_89_32_87_D4_76_90_33;
    localparam logic [63:0] ACT_B = 64'hAA_89_32_00_D4_00_00_33;

    initial begin
        logic [63:0] d;
        logic [7:0]  qz;
        rst_n = 1'b0;
        in_s = 64'h0; inst_s = 2'b00; qz_s = 8'h00; clr_s = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // basic dot product with unit weights
        cycle(64'h01010101_01010101, 2'b01, 8'h00, 1'b0);
        cycle(ACT_A, 2'b10, 8'h00, 1'b1);
        idle();
        chk("tp1_psum", $signed(if24.psum_out), 1017);
        chk("tp1_valid", if24.valid_out, 1);
        idle();
        chk("tp1_valid_once", if24.valid_out, 0);
        chk("tp1_cnt", if24.gated_cnt, 0);

        // partial q_zero gating, accumulate
        cycle(ACT_B, 2'b10, 8'h16, 1'b0);
        idle();
        chk("tp2_psum", $signed(if24.psum_out), 1637);
        chk("tp2_cnt", if24.gated_cnt, 3);

        // q_zero overrides nonzero activations
        cycle(ACT_A, 2'b10, 8'hFF, 1'b0);
        idle();
        chk("tp3_psum", $signed(if24.psum_out), 1637);
        chk("tp3_valid", if24.valid_out, 1);
        chk("tp3_cnt", if24.gated_cnt, 11);

        // negative and zero weights, back-to-back executes
        cycle(64'h00000000_FFFFFFFF, 2'b01, 8'h00, 1'b0);
        chk("tp4_wzero", if24.w_zero, 8'hF0);
        cycle({8{8'h10}}, 2'b10, 8'h00, 1'b1);
        cycle({8{8'h10}}, 2'b10, 8'h00, 1'b0);
        chk("tp4_psum_a", $signed(if24.psum_out), -64);
        chk("tp4_valid_a", if24.valid_out, 1);
        idle();
        chk("tp4_psum_b", $signed(if24.psum_out), -128);
        chk("tp4_valid_b", if24.valid_out, 1);
        chk("tp4_cnt", if24.gated_cnt, 19);

        // saturation of the 12-bit tile
        cycle({8{8'h7F}}, 2'b01, 8'h00, 1'b0);
        cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b1);
        cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b0);
        chk("tp5_sat12_a", $signed(if12.psum_out), 2047);
        idle();
        chk("tp5_sat12_b", $signed(if12.psum_out), 2047);
        chk("tp5_psum24", $signed(if24.psum_out), 518160);
        cycle({8{8'h81}}, 2'b01, 8'h00, 1'b0);
        cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b1);
        idle();
        chk("tp5_sat12_neg", $signed(if12.psum_out), -2048);

        // saturation of the 24-bit tile at both rails
        cycle({8{8'h7F}}, 2'b01, 8'h00, 1'b0);
        cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b1);
        repeat (40) cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b0);
        idle();
        chk("sat24_pos", $signed(if24.psum_out), 8388607);
        cycle({8{8'h81}}, 2'b01, 8'h00, 1'b0);
        cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b1);
        repeat (40) cycle({8{8'hFF}}, 2'b10, 8'h00, 1'b0);
        idle();
        chk("sat24_neg", $signed(if24.psum_out), -8388608);

        // load and execute together: execute sees the old weights (-127)
        cycle({8{8'h02}}, 2'b11, 8'h00, 1'b1);
        idle();
        chk("ldex_psum", $signed(if24.psum_out), -2032);
        chk("ldex_wzero", if24.w_zero, 8'h00);

        // clear without execute
        cycle(64'h0, 2'b00, 8'h00, 1'b1);
        idle();
        chk("clr_psum", $signed(if24.psum_out), 0);
        chk("clr_valid", if24.valid_out, 0);

        // reset during an execute
        cycle(ACT_A, 2'b10, 8'h00, 1'b0);
        in_s = 64'h0; inst_s = 2'b00; qz_s = 8'h00; clr_s = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("rst_no_valid", if24.valid_out, 0);
        cycle(ACT_A, 2'b10, 8'h00, 1'b1);
        idle();
        chk("rst_psum", $signed(if24.psum_out), 0);
        chk("rst_wzero", if24.w_zero, 8'h00);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++) begin
                d[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            qz = 8'($urandom) & 8'($urandom);
            cycle(d, 2'($urandom_range(0, 3)), qz, ($urandom_range(0, 4) == 0));
        end

        // gated-count saturation
        repeat (8200) cycle(64'h0, 2'b10, 8'hFF, 1'b0);
        idle();
        chk("cnt_sat", if24.gated_cnt, CNT_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
